systolic_feeder: RTL and testbench

- Front-end transmitter for the array44 / PE_Array systolic multiplier.
- Accepts two complete SIZE x SIZE matrices A and B through a valid/ready handshake and captures them.
- Drives the diagonally skewed AB and BB lane streams and the array's synchronous clear, then flags when the array's PAB outputs hold C = A x B.
- Results are held until the consumer acknowledges them.

---
 rtl/systolic_feeder_pkg.sv | 27 ++
 rtl/systolic_feeder_if.sv | 27 ++
 rtl/systolic_lane_select.sv | 24 ++
 rtl/systolic_feeder.sv | 99 +++++++++
 tb/tb_systolic_feeder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types and sizing for the systolic array feeder.
// Element (r,c) of a packed matrix sits at bit (r*SIZE+c)*DW.
package systolic_feeder_pkg;

   localparam int SIZE     = 4;
   localparam int DW       = 8;
   localparam int FEED_LEN = 3*SIZE-2;
   localparam int CNT_W    = $clog2(FEED_LEN);
   localparam int MAT_W    = SIZE*SIZE*DW;
   localparam int LANE_W   = SIZE*DW;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      FEED,
      DONE
   } state_e;

   function automatic int elem_lsb(input int r, input int c);
      return (r*SIZE + c)*DW;
   endfunction

   function automatic int row_lsb(input int r);
      return elem_lsb(r, 0);
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Job-in / result-out handshake plus the array-facing lane bus.
// The feeder connects through the slave view.
interface systolic_feeder_if;
   import systolic_feeder_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [MAT_W-1:0]  mat_a;
   logic [MAT_W-1:0]  mat_b;
   logic [LANE_W-1:0] AB;
   logic [LANE_W-1:0] BB;
   logic              pe_clear;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   modport slave (
      input  in_valid, mat_a, mat_b, out_ready,
      output in_ready, AB, BB, pe_clear, out_valid, busy
   );

   modport master (
      output in_valid, mat_a, mat_b, out_ready,
      input  in_ready, AB, BB, pe_clear, out_valid, busy
   );

endinterface

// File: rtl/systolic_lane_select.sv
// Picks the element a lane carries at step t: vec[t-lane], or 0
// outside the SIZE-wide skew window.
module systolic_lane_select
   import systolic_feeder_pkg::*;
(
   input  logic [LANE_W-1:0] vec_i,
   input  logic [CNT_W-1:0]  lane_i,
   input  logic [CNT_W-1:0]  t_i,
   output logic [DW-1:0]     elem_o
);

   logic [CNT_W-1:0] k;

   always_comb begin
      elem_o = '0;
      k      = t_i - lane_i;
      if (t_i >= lane_i) begin
         for (int i = 0; i < SIZE; i++) begin
            if (k == CNT_W'(i)) elem_o = vec_i[i*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Captures A and B, then streams them skewed into the PE array
// and holds the result flag until acknowledged.
module systolic_feeder
   import systolic_feeder_pkg::*;
(
   input logic              clk,
   input logic              reset_n,
   systolic_feeder_if.slave bus
);

   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(FEED_LEN-1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  t_q, t_d;
   logic [MAT_W-1:0]  a_q, b_q;
   logic [LANE_W-1:0] ab_q, ab_d, ab_sel;
   logic [LANE_W-1:0] bb_q, bb_d, bb_sel;
   logic              accept, load;

   assign accept = (state_q == IDLE) && bus.in_valid;
   assign load   = (state_q == CLEAR) ||
                   ((state_q == FEED) && (t_q != T_LAST));

   // t_d is the step whose values the lanes present next cycle
   for (genvar l = 0; l < SIZE; l++) begin : g_lane
      logic [LANE_W-1:0] col;

      for (genvar k = 0; k < SIZE; k++) begin : g_col
         assign col[k*DW +: DW] = b_q[elem_lsb(k, l) +: DW];
      end

      systolic_lane_select u_ab (
         .vec_i  (a_q[row_lsb(l) +: LANE_W]),
         .lane_i (CNT_W'(l)),
         .t_i    (t_d),
         .elem_o (ab_sel[l*DW +: DW])
      );

      systolic_lane_select u_bb (
         .vec_i  (col),
         .lane_i (CNT_W'(l)),
         .t_i    (t_d),
         .elem_o (bb_sel[l*DW +: DW])
      );
   end

   assign ab_d = load ? ab_sel : '0;
   assign bb_d = load ? bb_sel : '0;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) state_d = CLEAR;
         end
         CLEAR: begin
            state_d = FEED;
            t_d     = '0;
         end
         FEED: begin
            if (t_q == T_LAST) state_d = DONE;
            else               t_d     = t_q + CNT_W'(1);
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ab_q    <= '0;
         bb_q    <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         ab_q    <= ab_d;
         bb_q    <= bb_d;
         if (accept) begin
            a_q <= bus.mat_a;
            b_q <= bus.mat_b;
         end
      end
   end

   assign bus.AB        = ab_q;
   assign bus.BB        = bb_q;
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.pe_clear  = (state_q == IDLE) || (state_q == CLEAR);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder with a behavioural 4x4 PE array
// model and a scoreboard of expected C matrices.
module tb_systolic_feeder;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MW = N*N*W;
   localparam int LW = N*W;

   typedef logic [MW-1:0] mat_t;
   typedef logic [LW-1:0] lane_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   mat_t sb[$];

   logic [W-1:0] acc[N][N];
   logic [W-1:0] ar[N][N];
   logic [W-1:0] br[N][N];

   systolic_feeder_if bus();

   systolic_feeder dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // PE(m,n): a moves right, b moves down, synchronous clear
   always @(posedge clk) begin
      for (int m = 0; m < N; m++) begin
         for (int n = 0; n < N; n++) begin
            logic [W-1:0] ai, bi;
            if (n == 0) ai = bus.AB[m*W +: W];
            else        ai = ar[m][n-1];
            if (m == 0) bi = bus.BB[n*W +: W];
            else        bi = br[m-1][n];
            if (bus.pe_clear) begin
               acc[m][n] <= '0;
               ar[m][n]  <= '0;
               br[m][n]  <= '0;
            end else begin
               acc[m][n] <= acc[m][n] + ai*bi;
               ar[m][n]  <= ai;
               br[m][n]  <= bi;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [MW-1:0] got,
                        input logic [MW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] el(input mat_t mx, input int r,
                                       input int c);
      return mx[(r*N+c)*W +: W];
   endfunction

   function automatic mat_t fill(input int kind);
      mat_t mx;
      int   v;
      mx = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            case (kind)
               0:       v = (r == c) ? 1 : 0;
               1:       v = r*4 + c + 1;
               2:       v = 1;
               3:       v = 16*r + c;
               4:       v = 16*r + c + 8;
               default: v = 255;
            endcase
            mx[(r*N+c)*W +: W] = v[W-1:0];
         end
      end
      return mx;
   endfunction

   function automatic mat_t rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic mat_t matmul(input mat_t a, input mat_t b);
      mat_t cm;
      int   s;
      cm = '0;
      for (int m = 0; m < N; m++) begin
         for (int n = 0; n < N; n++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += el(a, m, k) * el(b, k, n);
            cm[(m*N+n)*W +: W] = s[W-1:0];
         end
      end
      return cm;
   endfunction

   function automatic lane_t ab_exp(input mat_t a, input int t);
      lane_t v;
      v = '0;
      for (int l = 0; l < N; l++)
         if (t-l >= 0 && t-l < N) v[l*W +: W] = el(a, l, t-l);
      return v;
   endfunction

   function automatic lane_t bb_exp(input mat_t b, input int t);
      lane_t v;
      v = '0;
      for (int l = 0; l < N; l++)
         if (t-l >= 0 && t-l < N) v[l*W +: W] = el(b, t-l, l);
      return v;
   endfunction

   function automatic mat_t pab();
      mat_t v;
      for (int m = 0; m < N; m++)
         for (int n = 0; n < N; n++)
            v[(m*N+n)*W +: W] = acc[m][n];
      return v;
   endfunction

   task automatic run_job(input mat_t a, input mat_t b, input int stall);
      mat_t exp_c;
      int   cyc;
      @(negedge clk);
      bus.mat_a    = a;
      bus.mat_b    = b;
      bus.in_valid = 1'b1;
      check("accept_rdy", bus.in_ready, 1);
      @(posedge clk);
      sb.push_back(matmul(a, b));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.mat_a    = rnd();
      bus.mat_b    = rnd();
      check("clear_ctl", {bus.in_ready, bus.pe_clear, bus.busy}, 3'b011);
      cyc = 1;
      while (!bus.out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc >= 2 && cyc <= 11) begin
            check("ab_lane", bus.AB, ab_exp(a, cyc-2));
            check("bb_lane", bus.BB, bb_exp(b, cyc-2));
            check("feed_clr", {bus.pe_clear, bus.busy}, 2'b01);
         end
      end
      check("latency", cyc, 12);
      exp_c = (sb.size() > 0) ? sb.pop_front() : 'x;
      check("pab", pab(), exp_c);
      check("done_lanes", {bus.AB, bus.BB}, 0);
      check("done_clr", bus.pe_clear, 0);
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = i[0];
         bus.mat_a    = rnd();
         bus.mat_b    = rnd();
         @(negedge clk);
         check("hold_valid", bus.out_valid, 1);
         check("hold_rdy", bus.in_ready, 0);
         check("hold_pab", pab(), exp_c);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = (stall > 0);
      @(negedge clk);
      check("ack_idle", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end");
      $fatal(1);
   end

   initial begin
      mat_t a, b;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.mat_a     = '0;
      bus.mat_b     = '0;
      repeat (2) @(negedge clk);
      check("rst_lanes", {bus.AB, bus.BB}, 0);
      check("rst_ctl",
            {bus.in_ready, bus.pe_clear, bus.out_valid, bus.busy}, 4'b1100);
      rst_n = 1'b1;

      run_job(fill(0), fill(1), 0);
      run_job(fill(2), fill(2), 0);
      run_job(fill(3), fill(4), 0);
      run_job(fill(5), fill(5), 0);
      run_job(rnd(), rnd(), 20);
      run_job(rnd(), rnd(), 0);

      a = fill(3);
      b = fill(4);
      @(negedge clk);
      bus.mat_a    = a;
      bus.mat_b    = b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_abort_ab", bus.AB, ab_exp(a, 5));
      check("pre_abort_bb", bus.BB, bb_exp(b, 5));
      rst_n = 1'b0;
      #1;
      check("abort_lanes", {bus.AB, bus.BB}, 0);
      check("abort_ctl",
            {bus.pe_clear, bus.out_valid, bus.in_ready, bus.busy}, 4'b1010);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_job(rnd(), rnd(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
